// File: rtl/writeback_top.sv
// WRITEBACK stage: merges pipeline results and a buffered long-latency result stream onto one regfile write port.
// Defining WB_STARVE_EN adds a starvation counter that raises stall_pipe to force a FIFO drain.
`ifndef REG_ADDR
`define REG_ADDR 5
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module writeback_top #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_regwrite,
    input  logic                         mem_memtoreg,
    input  logic [`REG_ADDR-1:0]         mem_dst_reg,
    input  logic [`REG_SIZE-1:0]         mem_alu_result,
    input  logic [`REG_SIZE-1:0]         mem_load_data,
    input  logic                         ll_valid,
    output logic                         ll_ready,
    input  logic [`REG_ADDR-1:0]         ll_dst_reg,
    input  logic [`REG_SIZE-1:0]         ll_data,
    output logic                         regwrite,
    output logic [`REG_ADDR-1:0]         wreg,
    output logic [`REG_SIZE-1:0]         wdata,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         stall_pipe
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [`REG_ADDR-1:0] dst_q  [FIFO_DEPTH];
    logic [`REG_ADDR-1:0] dst_d  [FIFO_DEPTH];
    logic [`REG_SIZE-1:0] data_q [FIFO_DEPTH];
    logic [`REG_SIZE-1:0] data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic regwrite_q, regwrite_d;
    logic [`REG_ADDR-1:0] wreg_q, wreg_d;
    logic [`REG_SIZE-1:0] wdata_q, wdata_d;
    logic handshake, push, push_vld, pop;

    assign ll_ready   = (count_q < CW'(FIFO_DEPTH));
    assign handshake  = ll_valid && ll_ready;
    assign regwrite   = regwrite_q;
    assign wreg       = wreg_q;
    assign wdata      = wdata_q;
    assign fifo_count = count_q;

    // Priority: pipeline write, then FIFO drain, then direct LL bypass when the FIFO is empty.
    always_comb begin
        dst_d      = dst_q;
        data_d     = data_q;
        vld_d      = vld_q;
        head_d     = head_q;
        tail_d     = tail_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        push       = 1'b0;
        push_vld   = 1'b1;
        pop        = 1'b0;
        if (mem_regwrite) begin
            regwrite_d = 1'b1;
            wreg_d     = mem_dst_reg;
            wdata_d    = mem_memtoreg ? mem_load_data : mem_alu_result;
            // The pipeline write is younger, so older buffered results to the same register must never land.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (dst_q[i] == mem_dst_reg) vld_d[i] = 1'b0;
            end
            push     = handshake;
            push_vld = (ll_dst_reg != mem_dst_reg);
        end else if (count_q != '0) begin
            pop        = 1'b1;
            regwrite_d = vld_q[head_q];
            if (vld_q[head_q]) begin
                wreg_d  = dst_q[head_q];
                wdata_d = data_q[head_q];
            end
            push = handshake;
        end else if (handshake) begin
            regwrite_d = 1'b1;
            wreg_d     = ll_dst_reg;
            wdata_d    = ll_data;
        end
        if (push) begin
            dst_d[tail_q]  = ll_dst_reg;
            data_d[tail_q] = ll_data;
            vld_d[tail_q]  = push_vld;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) head_d = head_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            vld_q      <= vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Payload storage needs no reset; the valid bits and count gate its use.
    always_ff @(posedge clk) begin
        dst_q  <= dst_d;
        data_q <= data_d;
    end

`ifdef WB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    logic stall_q, stall_d;

    // Count pipeline writes that block a non-empty FIFO; once the limit is hit, stall until the FIFO empties.
    always_comb begin
        starve_d = starve_q;
        if (count_q == '0 || pop) begin
            starve_d = '0;
        end else if (mem_regwrite && starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (count_d != '0) && (stall_q || starve_d >= SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_pipe = stall_q;
`else
    assign stall_pipe = 1'b0;
`endif
endmodule
